bus_dest_regfile: RTL

Receiving end of the datapath bus: it takes the 32-bit word driven onto `BusMuxOut` and writes it into the destination named by a 5-bit destination code. The code space uses the same numbering as the bus source select, so a destination code and a source code name the same storage element. The block holds R0–R15, LO, HI, PC, MAR, IR and OutPort. It feeds their values back to the bus multiplexer inputs and drives a valid/ack handshake toward the output-port device.

---
 rtl/bus_dest_regfile.sv | 122 ++++++++++++
 1 files changed

// File: rtl/bus_dest_regfile.sv
// Bus destination register file: writes BusMuxOut into the register named by a
// 5-bit destination code and hands OutPort values to the output device via valid/ack.
module bus_dest_regfile #(
    parameter int unsigned wordSize = 32
) (
    input  logic                clock,
    input  logic                clear,
    input  logic [wordSize-1:0] BusMuxOut,
    input  logic                wr_valid,
    input  logic [4:0]          wr_dest,
    output logic                wr_ready,
    input  logic                pc_inc,
    input  logic                out_ack,
    output logic                out_valid,
    output logic [wordSize-1:0] R0_q,
    output logic [wordSize-1:0] R1_q,
    output logic [wordSize-1:0] R2_q,
    output logic [wordSize-1:0] R3_q,
    output logic [wordSize-1:0] R4_q,
    output logic [wordSize-1:0] R5_q,
    output logic [wordSize-1:0] R6_q,
    output logic [wordSize-1:0] R7_q,
    output logic [wordSize-1:0] R8_q,
    output logic [wordSize-1:0] R9_q,
    output logic [wordSize-1:0] R10_q,
    output logic [wordSize-1:0] R11_q,
    output logic [wordSize-1:0] R12_q,
    output logic [wordSize-1:0] R13_q,
    output logic [wordSize-1:0] R14_q,
    output logic [wordSize-1:0] R15_q,
    output logic [wordSize-1:0] LO_q,
    output logic [wordSize-1:0] HI_q,
    output logic [wordSize-1:0] PC_q,
    output logic [wordSize-1:0] MAR_q,
    output logic [wordSize-1:0] IR_q,
    output logic [wordSize-1:0] OutPort_q,
    output logic                dest_err
);

    localparam logic [4:0] DEST_LO      = 5'd16;
    localparam logic [4:0] DEST_HI      = 5'd17;
    localparam logic [4:0] DEST_PC      = 5'd20;
    localparam logic [4:0] DEST_MAR     = 5'd21;
    localparam logic [4:0] DEST_OUTPORT = 5'd22;
    localparam logic [4:0] DEST_IR      = 5'd23;

    typedef enum logic {
        IDLE,
        OUT_WAIT
    } state_t;

    state_t              state;
    logic [wordSize-1:0] gpr [16];
    logic                accept;

    assign wr_ready = (state == IDLE) && !clear;
    assign accept   = wr_valid && wr_ready;

    // Register file, PC increment and OutPort handshake FSM
    always_ff @(posedge clock) begin
        if (clear) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            dest_err  <= 1'b0;
            LO_q      <= '0;
            HI_q      <= '0;
            PC_q      <= '0;
            MAR_q     <= '0;
            IR_q      <= '0;
            OutPort_q <= '0;
            for (int i = 0; i < 16; i++) begin
                gpr[i] <= '0;
            end
        end else begin
            // A bus write to PC is assigned later and so overrides the increment
            if (pc_inc) begin
                PC_q <= PC_q + wordSize'(1);
            end
            if (accept) begin
                if (!wr_dest[4]) begin
                    gpr[wr_dest[3:0]] <= BusMuxOut;
                end else begin
                    case (wr_dest)
                        DEST_LO:  LO_q  <= BusMuxOut;
                        DEST_HI:  HI_q  <= BusMuxOut;
                        DEST_PC:  PC_q  <= BusMuxOut;
                        DEST_MAR: MAR_q <= BusMuxOut;
                        DEST_IR:  IR_q  <= BusMuxOut;
                        DEST_OUTPORT: begin
                            OutPort_q <= BusMuxOut;
                            out_valid <= 1'b1;
                            state     <= OUT_WAIT;
                        end
                        default:  dest_err <= 1'b1;
                    endcase
                end
            end
            if (state == OUT_WAIT && out_ack) begin
                out_valid <= 1'b0;
                state     <= IDLE;
            end
        end
    end

    assign R0_q  = gpr[0];
    assign R1_q  = gpr[1];
    assign R2_q  = gpr[2];
    assign R3_q  = gpr[3];
    assign R4_q  = gpr[4];
    assign R5_q  = gpr[5];
    assign R6_q  = gpr[6];
    assign R7_q  = gpr[7];
    assign R8_q  = gpr[8];
    assign R9_q  = gpr[9];
    assign R10_q = gpr[10];
    assign R11_q = gpr[11];
    assign R12_q = gpr[12];
    assign R13_q = gpr[13];
    assign R14_q = gpr[14];
    assign R15_q = gpr[15];

endmodule
